rope_collision_detector: RTL and testbench

ROPE_COLLISION_DETECTOR -- requirements
Module: rope_collision_detector

---
 rtl/rope_collision_detector.sv | 224 ++++++++++++++++++++++
 tb/tb_rope_collision_detector.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rope_collision_detector.sv
// rope_collision_detector
//
// Watches the per-pixel drawing requests of the rope and the player during
// each video frame and turns them into frame-level game events:
//   * a debounced "player holds the rope" level (grab/release hysteresis),
//   * a one-cycle pulse that reverses the rope swing when the rope touches a
//     horizontal screen edge, rate-limited by a per-frame cooldown,
//   * the X column where the grab happened,
//   * an optional saturating count of frames that contained an overlap.
//
// A frame is everything sampled from one startOfFrame pulse (inclusive) up
// to the next one (exclusive). The clock edge that samples startOfFrame=1
// evaluates the finished frame and restarts the accumulators with the
// current-cycle sample, so every frame-level output changes one cycle after
// the pulse is presented.
//
// Optional feature macro: ROPE_HIT_COUNTER_EN
//   defined   -> hitCount counts overlap frames, saturating at 255
//   undefined -> hitCount is tied to 0 and no counter is built
//
// Parameters:
//   GRAB_FRAMES     consecutive overlap frames that latch a grab   (1..7)
//   RELEASE_FRAMES  consecutive clean frames that release          (1..7)
//   COOLDOWN_FRAMES frames dirToggle stays suppressed after a toggle (0..15)
//   LEFT_X/RIGHT_X  screen-edge columns that trigger a direction toggle
//
// Ports:
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle frame-start pulse
//   pixelX/pixelY current VGA pixel coordinates (pixelY is not needed here)
//   ropeDR        rope drawing request for the current pixel
//   playerDR      player drawing request for the current pixel
//   dirToggle     one-cycle pulse: reverse the rope swing direction
//   playerOnRope  level: the player holds the rope
//   grabX         pixelX of the first overlap in the frame that latched the grab
//   hitCount      number of frames containing an overlap
module rope_collision_detector #(
    parameter int GRAB_FRAMES     = 2,
    parameter int RELEASE_FRAMES  = 3,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int LEFT_X          = 0,
    parameter int RIGHT_X         = 639
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        ropeDR,
    input  logic        playerDR,
    output logic        dirToggle,
    output logic        playerOnRope,
    output logic [10:0] grabX,
    output logic [7:0]  hitCount
);

    localparam logic [10:0] LEFT_COL  = 11'(LEFT_X);
    localparam logic [10:0] RIGHT_COL = 11'(RIGHT_X);
    localparam logic [3:0]  GRAB_N    = 4'(GRAB_FRAMES);
    localparam logic [3:0]  REL_N     = 4'(RELEASE_FRAMES);
    localparam logic [3:0]  COOL_N    = 4'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        GRAB_PEND = 2'd1,
        ON_ROPE   = 2'd2,
        REL_PEND  = 2'd3
    } state_t;

    // Grab FSM state; kept as a named signal so checkers can bind to it.
    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [3:0]  cnt_inc;
    logic [3:0]  cooldown;

    logic        overlap_seen, edge_seen;
    logic [10:0] first_x;
    logic        sample_ov, sample_edge;
    logic        toggle_now, grab_load;

    // Vertical position plays no part in the collision rules.
    logic unused_pixel_y;
    assign unused_pixel_y = ^pixelY;

    assign sample_ov   = ropeDR && playerDR;
    assign sample_edge = ropeDR && ((pixelX <= LEFT_COL) || (pixelX >= RIGHT_COL));

    // Frame accumulators. On a startOfFrame edge the old contents are the
    // finished frame's result and the new frame begins with this cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overlap_seen <= 1'b0;
            edge_seen    <= 1'b0;
            first_x      <= '0;
        end else if (startOfFrame) begin
            overlap_seen <= sample_ov;
            edge_seen    <= sample_edge;
            first_x      <= sample_ov ? pixelX : 11'd0;
        end else begin
            if (sample_ov && !overlap_seen) begin
                first_x <= pixelX;
            end
            overlap_seen <= overlap_seen | sample_ov;
            edge_seen    <= edge_seen | sample_edge;
        end
    end

    // Direction toggle with per-frame cooldown.
    assign toggle_now = startOfFrame && edge_seen && (cooldown == 4'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown  <= 4'd0;
            dirToggle <= 1'b0;
        end else begin
            dirToggle <= toggle_now;
            if (toggle_now) begin
                cooldown <= COOL_N;
            end else if (startOfFrame && (cooldown != 4'd0)) begin
                cooldown <= cooldown - 4'd1;
            end
        end
    end

    // Grab FSM: state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= FREE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign cnt_inc = {1'b0, cnt} + 4'd1;

    // Grab FSM: next state, advanced once per evaluated frame.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (startOfFrame) begin
            case (state)
                FREE: begin
                    if (overlap_seen) begin
                        if (GRAB_N == 4'd1) begin
                            state_nxt = ON_ROPE;
                            cnt_nxt   = 3'd0;
                        end else begin
                            state_nxt = GRAB_PEND;
                            cnt_nxt   = 3'd1;
                        end
                    end
                end
                GRAB_PEND: begin
                    if (overlap_seen) begin
                        if (cnt_inc == GRAB_N) begin
                            state_nxt = ON_ROPE;
                            cnt_nxt   = 3'd0;
                        end else begin
                            cnt_nxt = cnt_inc[2:0];
                        end
                    end else begin
                        state_nxt = FREE;
                        cnt_nxt   = 3'd0;
                    end
                end
                ON_ROPE: begin
                    if (!overlap_seen) begin
                        if (REL_N == 4'd1) begin
                            state_nxt = FREE;
                            cnt_nxt   = 3'd0;
                        end else begin
                            state_nxt = REL_PEND;
                            cnt_nxt   = 3'd1;
                        end
                    end
                end
                REL_PEND: begin
                    if (overlap_seen) begin
                        state_nxt = ON_ROPE;
                        cnt_nxt   = 3'd0;
                    end else if (cnt_inc == REL_N) begin
                        state_nxt = FREE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt_inc[2:0];
                    end
                end
                default: begin
                    state_nxt = FREE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign playerOnRope = (state == ON_ROPE) || (state == REL_PEND);

    // grabX only captures a fresh grab; re-grabbing from REL_PEND keeps it.
    assign grab_load = (state_nxt == ON_ROPE) && ((state == FREE) || (state == GRAB_PEND));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            grabX <= '0;
        end else if (grab_load) begin
            grabX <= first_x;
        end
    end

`ifdef ROPE_HIT_COUNTER_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitCount <= 8'd0;
        end else if (startOfFrame && overlap_seen && (hitCount != 8'd255)) begin
            hitCount <= hitCount + 8'd1;
        end
    end
`else
    assign hitCount = 8'd0;
`endif

endmodule

// File: tb/tb_rope_collision_detector.sv
// tb_rope_collision_detector
//
// Directed bench for rope_collision_detector with default parameters.
// A frame-level model (run lengths of overlap / clean frames, frames since
// the last toggle) predicts the outputs every cycle and feeds an expected
// queue; a compare process pops it on each falling edge. Hand-computed
// literal checks at key points pin the model itself.
// Honours ROPE_HIT_COUNTER_EN the same way as the design.
module tb_rope_collision_detector;

    localparam int G  = 2;
    localparam int R  = 3;
    localparam int C  = 4;
    localparam int LX = 0;
    localparam int RX = 639;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        ropeDR = 1'b0;
    logic        playerDR = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;

    logic        dirToggle;
    logic        playerOnRope;
    logic [10:0] grabX;
    logic [7:0]  hitCount;

    always #5 clk = ~clk;

    rope_collision_detector #(
        .GRAB_FRAMES(G), .RELEASE_FRAMES(R), .COOLDOWN_FRAMES(C),
        .LEFT_X(LX), .RIGHT_X(RX)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(sof),
        .pixelX(px),
        .pixelY(py),
        .ropeDR(ropeDR),
        .playerDR(playerDR),
        .dirToggle(dirToggle),
        .playerOnRope(playerOnRope),
        .grabX(grabX),
        .hitCount(hitCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // expected {dirToggle, playerOnRope, grabX, hitCount}
    logic [20:0] exp_q[$];

    // ---------------- frame-level model ----------------
    bit          acc_ov, acc_edge;
    int          acc_fx;
    bit          m_on_rope, m_tog;
    int          ov_run, clean_run, since_tog, m_hits;
    logic [10:0] m_grabx;

    task automatic m_reset();
        acc_ov = 0; acc_edge = 0; acc_fx = 0;
        m_on_rope = 0; m_tog = 0;
        ov_run = 0; clean_run = 0; since_tog = 1000; m_hits = 0;
        m_grabx = '0;
    endtask

    initial begin
        bit s_ov, s_edge;
        m_reset();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                m_reset();
                exp_q.delete();
                exp_q.push_back(21'd0);
            end else begin
                s_ov   = ropeDR && playerDR;
                s_edge = ropeDR && ((int'(px) <= LX) || (int'(px) >= RX));
                m_tog  = 0;
                if (sof) begin
                    if (since_tog < 1000) since_tog++;
                    if (acc_edge && since_tog > C) begin
                        m_tog = 1;
                        since_tog = 0;
                    end
                    if (acc_ov) begin
                        if (m_hits < 255) m_hits++;
                        ov_run++;
                        clean_run = 0;
                    end else begin
                        clean_run++;
                        ov_run = 0;
                    end
                    if (!m_on_rope && ov_run >= G) begin
                        m_on_rope = 1;
                        m_grabx = 11'(acc_fx);
                    end else if (m_on_rope && clean_run >= R) begin
                        m_on_rope = 0;
                        ov_run = 0;
                    end
                    acc_ov   = s_ov;
                    acc_edge = s_edge;
                    acc_fx   = s_ov ? int'(px) : 0;
                end else begin
                    if (s_ov && !acc_ov) acc_fx = int'(px);
                    acc_ov   = acc_ov | s_ov;
                    acc_edge = acc_edge | s_edge;
                end
`ifdef ROPE_HIT_COUNTER_EN
                exp_q.push_back({m_tog, m_on_rope, m_grabx, 8'(m_hits)});
`else
                exp_q.push_back({m_tog, m_on_rope, m_grabx, 8'd0});
`endif
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_dirToggle",    int'(dirToggle),    int'(e[20]));
                chk("sb_playerOnRope", int'(playerOnRope), int'(e[19]));
                chk("sb_grabX",        int'(grabX),        int'(e[18:8]));
                chk("sb_hitCount",     int'(hitCount),     int'(e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic r, input logic p, input int x);
        @(negedge clk);
        sof      = s;
        ropeDR   = r;
        playerDR = p;
        px       = 11'(x);
        py       = 11'($urandom_range(0, 479));
    endtask

    // Frame body (no startOfFrame). ov adds overlaps starting at column x;
    // ek: 0 no edge, 1 rope at right edge, 2 rope at left edge.
    // Rope at columns 1 and 638 and player at 639 are near-edge non-triggers.
    task automatic body(input logic ov, input int x, input int ek);
        step(0, 1, 0, 1);
        step(0, 0, 1, 20);
        if (ov) begin
            step(0, 1, 1, x);
            step(0, 0, 0, x + 2);
            step(0, 1, 1, x + 5);
        end else begin
            step(0, 0, 0, x);
        end
        step(0, 1, 0, 638);
        if (ek == 1) step(0, 1, 0, 639);
        else if (ek == 2) step(0, 1, 0, 0);
        step(0, 0, 1, 639);
    endtask

    // Frame pulse; returns on the falling edge after the evaluation.
    task automatic pulse();
        step(1, 0, 0, 0);
        step(0, 0, 0, 5);
    endtask

    task automatic clean_frames(input int n);
        for (int i = 0; i < n; i++) begin
            body(0, 40, 0);
            pulse();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("reset_dirToggle", int'(dirToggle), 0);
        chk("reset_onRope", int'(playerOnRope), 0);
        chk("reset_grabX", int'(grabX), 0);
        chk("reset_hitCount", int'(hitCount), 0);
        @(posedge clk); #2 resetN = 1'b1;

        // grab after two overlap frames at x=100
        pulse();
        body(1, 100, 0); pulse();
        chk("grab_pending", int'(playerOnRope), 0);
        body(1, 100, 0); pulse();
        chk("grab_latched", int'(playerOnRope), 1);
        chk("grab_x100", int'(grabX), 100);

        // release hysteresis: re-grab from REL_PEND keeps grabX
        clean_frames(2);
        chk("relpend_holds", int'(playerOnRope), 1);
        body(1, 200, 0); pulse();
        chk("regrab_on", int'(playerOnRope), 1);
        chk("regrab_keeps_x", int'(grabX), 100);
        clean_frames(2);
        chk("release_2clean", int'(playerOnRope), 1);
        clean_frames(1);
        chk("release_3clean", int'(playerOnRope), 0);

        // single overlap frame then clean: back to FREE
        body(1, 50, 0); pulse();
        chk("single_ov_pend", int'(playerOnRope), 0);
        clean_frames(1);
        chk("single_ov_free", int'(playerOnRope), 0);
        body(1, 60, 0); pulse();
        chk("restart_cnt1", int'(playerOnRope), 0);
        body(1, 70, 0); pulse();
        chk("restart_grab", int'(playerOnRope), 1);
        chk("restart_grab_x", int'(grabX), 70);
        clean_frames(3);
        chk("restart_release", int'(playerOnRope), 0);

        // overlap sampled in the startOfFrame cycle belongs to the new frame
        step(1, 1, 1, 77); step(0, 0, 0, 5);
        body(0, 40, 0);
        step(1, 1, 1, 88); step(0, 0, 0, 5);
        chk("sof_sample_pend", int'(playerOnRope), 0);
        body(0, 40, 0); pulse();
        chk("sof_sample_grab", int'(playerOnRope), 1);
        chk("sof_sample_x", int'(grabX), 88);
        clean_frames(3);

        // edge toggles with cooldown: evaluations 1, 6, 11, 16
        for (int k = 1; k <= 16; k++) begin
            body(0, 40, (k <= 12) ? 1 : 2);
            pulse();
            chk($sformatf("toggle_frame%0d", k), int'(dirToggle), (k % 5 == 1) ? 1 : 0);
        end

        // reset mid-frame during GRAB_PEND
        body(1, 100, 0); pulse();
        chk("pre_reset_pend", int'(playerOnRope), 0);
        step(0, 1, 1, 110); step(0, 0, 0, 5);
        @(posedge clk); #2 resetN = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_onRope", int'(playerOnRope), 0);
        chk("midreset_grabX", int'(grabX), 0);
        chk("midreset_toggle", int'(dirToggle), 0);
        chk("midreset_hits", int'(hitCount), 0);
        @(posedge clk); #2 resetN = 1'b1;
        clean_frames(1);
        chk("post_reset_free", int'(playerOnRope), 0);
        body(1, 120, 0); pulse();
        chk("post_reset_cnt1", int'(playerOnRope), 0);
        body(1, 130, 0); pulse();
        chk("post_reset_grab", int'(playerOnRope), 1);
        chk("post_reset_x", int'(grabX), 130);

        // back-to-back startOfFrame pulses are separate frames
        body(0, 40, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 5);
        chk("b2b_relpend", int'(playerOnRope), 1);
        pulse();
        chk("b2b_released", int'(playerOnRope), 0);

        // 300 overlap frames (one cycle each, overlap in the sof cycle)
        for (int i = 0; i < 300; i++) step(1, 1, 1, 400);
        pulse();
        chk("sat_onRope", int'(playerOnRope), 1);
        chk("sat_grabX", int'(grabX), 400);
`ifdef ROPE_HIT_COUNTER_EN
        chk("sat_hitCount", int'(hitCount), 255);
`else
        chk("sat_hitCount", int'(hitCount), 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
